// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending transaction controller.
// Error codes, FSM encoding and saturating arithmetic.
package vend_pkg;

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_BAD_REQ  = 2'd1;
  localparam logic [1:0] ERR_NO_STOCK = 2'd2;
  localparam logic [1:0] ERR_NO_MONEY = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EVAL,
    S_SETL,
    S_RESP
  } state_e;

  // a + b clamped to the largest w-bit value (w <= 32)
  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b,
    input int unsigned w
  );
    logic [32:0] s;
    logic [32:0] m;
    s = {1'b0, a} + {1'b0, b};
    m = (33'd1 << w) - 33'd1;
    sat_add = (s > m) ? m[31:0] : s[31:0];
  endfunction

endpackage

// File: rtl/vend_inventory.sv
// Per-slot stock and price registers.
// Async read, restock write, commit decrement; restock wins.
module vend_inventory #(
  parameter int ID_W    = 3,
  parameter int QTY_W   = 4,
  parameter int PRICE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ID_W-1:0]    rd_id_i,
  output logic [QTY_W-1:0]   rd_qty_o,
  output logic [PRICE_W-1:0] rd_price_o,
  input  logic               wr_en_i,
  input  logic [ID_W-1:0]    wr_id_i,
  input  logic [QTY_W-1:0]   wr_qty_i,
  input  logic [PRICE_W-1:0] wr_price_i,
  input  logic               dec_en_i,
  input  logic [ID_W-1:0]    dec_id_i,
  input  logic [QTY_W-1:0]   dec_qty_i
);

  localparam int N_SLOTS = 2 ** ID_W;

  logic [QTY_W-1:0]   qty_q   [N_SLOTS];
  logic [QTY_W-1:0]   qty_d   [N_SLOTS];
  logic [PRICE_W-1:0] price_q [N_SLOTS];
  logic [PRICE_W-1:0] price_d [N_SLOTS];

  assign rd_qty_o   = qty_q[rd_id_i];
  assign rd_price_o = price_q[rd_id_i];

  // Decrement first, then let a restock overwrite the same slot
  always_comb begin
    qty_d   = qty_q;
    price_d = price_q;
    if (dec_en_i) begin
      qty_d[dec_id_i] = qty_q[dec_id_i] - dec_qty_i;
    end
    if (wr_en_i) begin
      qty_d[wr_id_i]   = wr_qty_i;
      price_d[wr_id_i] = wr_price_i;
    end
  end

  // Slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOTS; i++) begin
        qty_q[i]   <= '0;
        price_q[i] <= '0;
      end
    end else begin
      qty_q   <= qty_d;
      price_q <= price_d;
    end
  end

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: request FSM, bank, red light.
// Response appears two edges after the request is accepted.
module vend_txn_ctrl
  import vend_pkg::*;
#(
  parameter int ID_W    = 3,
  parameter int QTY_W   = 4,
  parameter int PRICE_W = 4,
  parameter int MONEY_W = 8,
  parameter int BANK_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ID_W-1:0]    req_id,
  input  logic [QTY_W-1:0]   req_qty,
  input  logic [MONEY_W-1:0] req_money,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_ok,
  output logic [1:0]         rsp_err,
  output logic [MONEY_W-1:0] rsp_cost,
  output logic [MONEY_W-1:0] rsp_change,
  input  logic               stock_we,
  input  logic [ID_W-1:0]    stock_id,
  input  logic [QTY_W-1:0]   stock_qty,
  input  logic [PRICE_W-1:0] stock_price,
  input  logic               bank_clr,
  output logic [BANK_W-1:0]  bank,
  output logic               red_light
);

  localparam int COST_W = PRICE_W + QTY_W;

  state_e state_q, state_d;

  logic [ID_W-1:0]    id_q, id_d;
  logic [QTY_W-1:0]   rq_qty_q, rq_qty_d;
  logic [MONEY_W-1:0] money_q, money_d;

  logic               ok_q, ok_d;
  logic [1:0]         err_q, err_d;
  logic [MONEY_W-1:0] cost_q, cost_d;
  logic [MONEY_W-1:0] chg_q, chg_d;
  logic [BANK_W-1:0]  bank_q, bank_d;
  logic               red_q, red_d;

  logic [QTY_W-1:0]   rd_qty;
  logic [PRICE_W-1:0] rd_price;
  logic [COST_W-1:0]  price_x, qty_x, cost;
  logic [MONEY_W-1:0] cost_m;
  logic [1:0]         err_c;
  logic               dec_en;

  vend_inventory #(
    .ID_W    (ID_W),
    .QTY_W   (QTY_W),
    .PRICE_W (PRICE_W)
  ) u_inv (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_id_i    (id_q),
    .rd_qty_o   (rd_qty),
    .rd_price_o (rd_price),
    .wr_en_i    (stock_we),
    .wr_id_i    (stock_id),
    .wr_qty_i   (stock_qty),
    .wr_price_i (stock_price),
    .dec_en_i   (dec_en),
    .dec_id_i   (id_q),
    .dec_qty_i  (rq_qty_q)
  );

  assign price_x = COST_W'(rd_price);
  assign qty_x   = COST_W'(rq_qty_q);
  assign cost    = price_x * qty_x;
  assign cost_m  = MONEY_W'(cost);

  // Classify the latched request against the current slot
  always_comb begin
    err_c = ERR_OK;
    if (rq_qty_q == '0 || rd_price == '0) begin
      err_c = ERR_BAD_REQ;
    end else if (rd_qty < rq_qty_q) begin
      err_c = ERR_NO_STOCK;
    end else if (cost_m > money_q) begin
      err_c = ERR_NO_MONEY;
    end
  end

  // Next state, commit and response registers
  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    rq_qty_d = rq_qty_q;
    money_d  = money_q;
    ok_d     = ok_q;
    err_d    = err_q;
    cost_d   = cost_q;
    chg_d    = chg_q;
    red_d    = red_q;
    dec_en   = 1'b0;
    bank_d   = bank_clr ? '0 : bank_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          id_d     = req_id;
          rq_qty_d = req_qty;
          money_d  = req_money;
          state_d  = S_EVAL;
        end
      end
      S_EVAL: begin
        ok_d  = (err_c == ERR_OK);
        err_d = err_c;
        red_d = (err_c != ERR_OK);
        if (err_c == ERR_OK) begin
          dec_en = 1'b1;
          cost_d = cost_m;
          chg_d  = money_q - cost_m;
          bank_d = BANK_W'(sat_add(
                     bank_clr ? 32'd0 : 32'(bank_q),
                     32'(cost), BANK_W));
        end else begin
          cost_d = '0;
          chg_d  = money_q;
        end
        state_d = S_SETL;
      end
      S_SETL: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          ok_d    = 1'b0;
          err_d   = ERR_OK;
          cost_d  = '0;
          chg_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      rq_qty_q <= '0;
      money_q  <= '0;
      ok_q     <= 1'b0;
      err_q    <= ERR_OK;
      cost_q   <= '0;
      chg_q    <= '0;
      bank_q   <= '0;
      red_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      rq_qty_q <= rq_qty_d;
      money_q  <= money_d;
      ok_q     <= ok_d;
      err_q    <= err_d;
      cost_q   <= cost_d;
      chg_q    <= chg_d;
      bank_q   <= bank_d;
      red_q    <= red_d;
    end
  end

  assign req_ready  = rst_n && (state_q == S_IDLE);
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_ok     = ok_q;
  assign rsp_err    = err_q;
  assign rsp_cost   = cost_q;
  assign rsp_change = chg_q;
  assign bank       = bank_q;
  assign red_light  = red_q;

endmodule
